// File: rtl/fault_alarm_handler.sv
// Alarm escalation stage behind the fault-attack invariant monitors: registers the raw alarms,
// detects alarm events, raises an interrupt and escalates to a latched halt.
module fault_alarm_handler #(
    parameter int NumMonitors   = 4,
    parameter int TimeoutCycles = 16,
    parameter int EscThreshold  = 3,
    parameter int CntWidth      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NumMonitors-1:0] alarm_i,
    input  logic                   clear_i,
    output logic                   irq_o,
    output logic                   halt_o,
    output logic [NumMonitors-1:0] alarm_src_o,
    output logic [CntWidth-1:0]    alarm_cnt_o,
    output logic [1:0]             state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ALERT   = 2'b01,
        ST_LOCK    = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_e;

    localparam logic [15:0]         TimerMax = 16'(TimeoutCycles - 1);
    localparam logic [7:0]          EscLast  = 8'(EscThreshold - 1);
    localparam logic [CntWidth-1:0] CntMax   = '1;

    state_e                  r_state;
    logic [NumMonitors-1:0]  r_alarm_q;
    logic                    r_any_qq;
    logic [NumMonitors-1:0]  r_alarm_src;
    logic [CntWidth-1:0]     r_alarm_cnt;
    logic [15:0]             r_timer;
    logic [7:0]              r_esc_cnt;

    logic                    w_ev;
    logic                    w_esc_hit;
    logic [7:0]              w_esc_inc;

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (v == CntMax) ? v : v + CntWidth'(1);
    endfunction

    // Event is the rising edge of the OR of all registered alarms.
    assign w_ev      = (|r_alarm_q) & ~r_any_qq;
    assign w_esc_hit = (r_esc_cnt >= EscLast);
    assign w_esc_inc = r_esc_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_alarm_q   <= '0;
            r_any_qq    <= 1'b0;
            r_alarm_src <= '0;
            r_alarm_cnt <= '0;
            r_timer     <= '0;
            r_esc_cnt   <= '0;
        end else begin
            r_alarm_q   <= alarm_i;
            r_any_qq    <= |r_alarm_q;
            r_alarm_src <= r_alarm_src | r_alarm_q;
            if (w_ev) begin
                r_alarm_cnt <= sat_inc(r_alarm_cnt);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_ev) begin
                        r_state   <= ST_ALERT;
                        r_timer   <= '0;
                        r_esc_cnt <= 8'd1;
                    end
                end
                ST_ALERT: begin
                    // A fresh event outranks a software acknowledge in the same cycle.
                    if (w_ev && w_esc_hit) begin
                        r_state   <= ST_LOCK;
                        r_esc_cnt <= w_esc_inc;
                    end else if (w_ev) begin
                        r_esc_cnt <= w_esc_inc;
                        r_timer   <= r_timer + 16'd1;
                    end else if (clear_i) begin
                        r_state     <= ST_IDLE;
                        r_timer     <= '0;
                        r_esc_cnt   <= '0;
                        r_alarm_src <= r_alarm_q;
                    end else if (r_timer == TimerMax) begin
                        r_state <= ST_LOCK;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                // LOCK and the unreachable 11 encoding both hold until reset.
                default: ;
            endcase
        end
    end

    assign state_o     = r_state;
    assign irq_o       = (r_state != ST_IDLE);
    assign halt_o      = r_state[1];
    assign alarm_src_o = r_alarm_src;
    assign alarm_cnt_o = r_alarm_cnt;

endmodule

// File: tb/tb_fault_alarm_handler.sv
// Scoreboard bench for fault_alarm_handler: directed stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them. A second instance uses a 2-bit event counter.
module tb_fault_alarm_handler;

    logic       clk;
    logic       rst_n;
    logic [3:0] alarm_i;
    logic       clear_i;

    logic       irq_a, halt_a;
    logic [3:0] src_a;
    logic [7:0] cnt_a;
    logic [1:0] st_a;

    logic       irq_b, halt_b;
    logic [3:0] src_b;
    logic [1:0] cnt_b;
    logic [1:0] st_b;

    fault_alarm_handler dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .alarm_i    (alarm_i),
        .clear_i    (clear_i),
        .irq_o      (irq_a),
        .halt_o     (halt_a),
        .alarm_src_o(src_a),
        .alarm_cnt_o(cnt_a),
        .state_o    (st_a)
    );

    fault_alarm_handler #(.CntWidth(2)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .alarm_i    (alarm_i),
        .clear_i    (clear_i),
        .irq_o      (irq_b),
        .halt_o     (halt_b),
        .alarm_src_o(src_b),
        .alarm_cnt_o(cnt_b),
        .state_o    (st_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         cyc;
        string      name;
        logic       irq;
        logic       halt;
        logic [3:0] src;
        logic [7:0] cnt;
        logic [1:0] st;
        logic [1:0] bcnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Expected outputs after the edge that produced the current cycle count.
    task automatic expect_now(input string name, input logic irq, input logic halt,
                              input logic [3:0] src, input logic [7:0] cnt, input logic [1:0] st);
        exp_t x;
        x.cyc  = cyc;
        x.name = name;
        x.irq  = irq;
        x.halt = halt;
        x.src  = src;
        x.cnt  = cnt;
        x.st   = st;
        x.bcnt = (cnt > 8'd3) ? 2'd3 : cnt[1:0];
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            chk({e.name, ".irq"},  int'(irq_a),  int'(e.irq));
            chk({e.name, ".halt"}, int'(halt_a), int'(e.halt));
            chk({e.name, ".src"},  int'(src_a),  int'(e.src));
            chk({e.name, ".cnt"},  int'(cnt_a),  int'(e.cnt));
            chk({e.name, ".st"},   int'(st_a),   int'(e.st));
            chk({e.name, ".bcnt"}, int'(cnt_b),  int'(e.bcnt));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        alarm_i = 4'b0000;
        clear_i = 1'b0;
        step(2);
        expect_now("reset", 0, 0, 4'b0000, 8'd0, 2'b00);

        // Single event, acknowledged
        rst_n   = 1'b1;
        alarm_i = 4'b0010;
        step(1);
        alarm_i = 4'b0000;
        expect_now("ack_reg", 0, 0, 4'b0000, 8'd0, 2'b00);
        step(1);
        expect_now("ack_irq", 1, 0, 4'b0010, 8'd1, 2'b01);
        step(3);
        expect_now("ack_hold", 1, 0, 4'b0010, 8'd1, 2'b01);
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
        expect_now("ack_clr", 0, 0, 4'b0000, 8'd1, 2'b00);

        // Timeout escalation
        alarm_i = 4'b0100;
        step(1);
        alarm_i = 4'b0000;
        step(1);
        expect_now("to_irq", 1, 0, 4'b0100, 8'd2, 2'b01);
        step(15);
        expect_now("to_pre", 1, 0, 4'b0100, 8'd2, 2'b01);
        step(1);
        expect_now("to_lock", 1, 1, 4'b0100, 8'd2, 2'b10);
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
        expect_now("lock_clr", 1, 1, 4'b0100, 8'd2, 2'b10);
        step(1);

        // Asynchronous reset while locked, checked between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.irq",  int'(irq_a),  0);
        chk("async_rst.halt", int'(halt_a), 0);
        chk("async_rst.src",  int'(src_a),  0);
        chk("async_rst.cnt",  int'(cnt_a),  0);
        chk("async_rst.st",   int'(st_a),   0);
        chk("async_rst.bcnt", int'(cnt_b),  0);
        step(1);
        rst_n = 1'b1;

        // Repeat escalation: three pulses on bit 0, three cycles apart
        alarm_i = 4'b0001;
        step(1);
        alarm_i = 4'b0000;
        step(1);
        expect_now("rep1", 1, 0, 4'b0001, 8'd1, 2'b01);
        step(1);
        alarm_i = 4'b0001;
        step(1);
        alarm_i = 4'b0000;
        step(1);
        expect_now("rep2", 1, 0, 4'b0001, 8'd2, 2'b01);
        step(1);
        alarm_i = 4'b0001;
        step(1);
        alarm_i = 4'b0000;
        step(1);
        expect_now("rep_lock", 1, 1, 4'b0001, 8'd3, 2'b10);
        step(1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;

        // Held alarm with a second source rising during the hold
        alarm_i = 4'b0010;
        step(3);
        alarm_i = 4'b1010;
        step(7);
        alarm_i = 4'b0000;
        step(1);
        expect_now("held", 1, 0, 4'b1010, 8'd1, 2'b01);
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
        expect_now("held_clr", 0, 0, 4'b0000, 8'd1, 2'b00);

        // Event coinciding with clear: event wins, stays in ALERT
        alarm_i = 4'b0100;
        step(1);
        alarm_i = 4'b0000;
        step(1);
        expect_now("sim_alert", 1, 0, 4'b0100, 8'd2, 2'b01);
        alarm_i = 4'b0001;
        step(1);
        alarm_i = 4'b0000;
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
        expect_now("sim_evclr", 1, 0, 4'b0101, 8'd3, 2'b01);
        // One more event must lock, which shows the episode count reached two
        alarm_i = 4'b0001;
        step(1);
        alarm_i = 4'b0000;
        step(1);
        expect_now("sim_lock", 1, 1, 4'b0101, 8'd4, 2'b10);
        // Events keep counting in LOCK; the 2-bit counter stays saturated
        alarm_i = 4'b0010;
        step(1);
        alarm_i = 4'b0000;
        step(1);
        expect_now("lock_cnt", 1, 1, 4'b0111, 8'd5, 2'b10);

        for (int i = 0; i < 20 && q.size() > 0; i++) step(1);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fault_alarm_handler.md
# fault_alarm_handler

Sequential alarm-escalation stage sitting directly downstream of the RI5CY fault-attack invariant monitors. Registers their combinational `alarm` outputs and detects alarm events. Raises an interrupt, then escalates to a latched core halt if software does not acknowledge in time or if alarms repeat. Its outputs drive the core interrupt line and gate `fetch_enable`.

## Interface
- `NumMonitors`, default 4: number of monitor alarm inputs, range 1..32.
- `TimeoutCycles`, default 16: cycles allowed in ALERT before escalation, range 2..2^16.
- `EscThreshold`, default 3: events counted in one ALERT episode that force LOCK, range 2..255.
- `CntWidth`, default 8: width of the lifetime event counter.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `alarm_i`, input, `NumMonitors`: raw combinational alarms, one per monitor.
- `clear_i`, input, 1: single-cycle acknowledge from software or debug.
- `irq_o`, output, 1: alert interrupt to the core.
- `halt_o`, output, 1: escalation; the core ANDs its `fetch_enable` with `!halt_o`.
- `alarm_src_o`, output, `NumMonitors`: sticky record of which monitors fired.
- `alarm_cnt_o`, output, `CntWidth`: lifetime count of alarm events, saturating.
- `state_o`, output, 2: FSM state encoding, IDLE=00, ALERT=01, LOCK=10.

## Operation
- **Input stage:** `alarm_q <= alarm_i` and `any_qq <= |alarm_q` every cycle. No combinational path exists from `alarm_i` to any output.
- **Event:** `ev = (|alarm_q) & !any_qq`, i.e. a rising edge of the OR of all alarms. An alarm held high continuously produces exactly one event. A new source rising while another is already high produces no new event, but is still recorded in `alarm_src_o`.
- **`alarm_cnt_o`:** increments by 1 on each `ev` in any state. Saturates at 2^CntWidth-1. Cleared only by reset.
- **`alarm_src_o`:** `alarm_src_o <= alarm_src_o | alarm_q` every cycle. It is cleared only on the ALERT->IDLE transition, and in that cycle it is loaded with `alarm_q` instead.
- **Internal counters:**
  - `timer` is 16 bits.
  - `esc_cnt` is 8 bits and saturates at `EscThreshold`.
- **IDLE:**
  - On `ev`: go to ALERT, set `timer`=0 and `esc_cnt`=1.
  - `clear_i` is ignored.
- **ALERT:** actions are evaluated in priority order.
  1. If `ev` and `esc_cnt+1 >= EscThreshold`: go to LOCK.
  2. Else if `ev`: `esc_cnt++`, `timer` continues counting. `clear_i` in the same cycle is ignored.
  3. Else if `clear_i`: go to IDLE; `timer` and `esc_cnt` are set to 0.
  4. Else if `timer == TimeoutCycles-1`: go to LOCK.
  5. Else: `timer++`.
- **LOCK:** terminal state; only `rst_n` exits it. `clear_i` is ignored. `alarm_src_o` and `alarm_cnt_o` keep accumulating.
- **Output decode:** `irq_o = (state != IDLE)`, `halt_o = (state == LOCK)`. Both are decoded only from the state register.
- **Illegal state 11:** treated as LOCK, with `halt_o=1` and `irq_o=1` (fail-secure).

## Timing
- **Reset values:**
  - `irq_o`=0, `halt_o`=0, `alarm_src_o`=0, `alarm_cnt_o`=0, `state_o`=00.
  - `alarm_q`, `any_qq`, `timer` and `esc_cnt` are all 0.
- **Reset mid-operation:** asynchronous reset clears all state immediately, including LOCK. The first `alarm_i` sampled after reset release can generate an event.
- **Event-to-output latency:**
  - `alarm_i` is high at edge E0, which sets `alarm_q`.
  - `ev` is true during the following cycle.
  - At edge E1, `irq_o`=1, `state_o`=01, `alarm_cnt_o`+1 and the `alarm_src_o` bit are all set.
- **Timeout:** with no clear and no event, LOCK is reached `TimeoutCycles` edges after entering ALERT. `halt_o` rises at that edge.
- **Clear:** `clear_i` high at edge E drops `irq_o` at E, provided no `ev` occurs that cycle. A clear arriving in the same cycle as the timeout compare wins.
- **Re-entry:** at least one cycle with `|alarm_q`=0 is required before a new event is detected.

## Test plan
- **Single event, acknowledged:** pulse `alarm_i`=4'b0010 for one cycle, then `clear_i` 5 cycles later.
  - Required: `irq_o`=1 two edges after the pulse, `alarm_src_o`=0010, `alarm_cnt_o`=1.
  - After the clear: IDLE, `irq_o`=0, `alarm_src_o`=0, `alarm_cnt_o` stays 1.
- **Timeout:** single event, no clear.
  - Required: `halt_o` rises exactly 16 edges after `irq_o` rises, `state_o`=10.
  - A subsequent `clear_i` has no effect.
- **Repeat escalation:** three separate one-cycle pulses on bit 0, spaced 3 cycles apart, no clear.
  - Required: LOCK at the edge after the third pulse is registered, `alarm_cnt_o`=3.
- **Held alarm and second source:** hold bit 1 high for 10 cycles, raise bit 3 during the hold, then release both and clear.
  - Required: `alarm_cnt_o`=1 and `alarm_src_o`=1010 before the clear.
- **Simultaneous event and clear:** in ALERT, pulse a new alarm so that `ev` coincides with `clear_i`.
  - Required: state stays ALERT, `esc_cnt`=2, `alarm_cnt_o`=2.
- **Reset mid-LOCK and saturation:** assert `rst_n`=0 asynchronously while in LOCK.
  - Required: all outputs return to 0 with no clock edge.
  - Separately, with `CntWidth`=2, send 5 events and check that `alarm_cnt_o` saturates at 3.
